data_plane_gen: RTL and testbench
=================================

# data_plane_gen

Parametrised second-generation data plane. It buffers GPP words in a TX FIFO and sends them as a framed burst of addressed packets when the control plane raises `data_tx_flag`. It filters incoming packets by destination node ID into an RX FIFO that the GPP drains. It sits between the GPP and the photonic data-plane link, alongside the control plane that issues the tx/rx flags.

## Interface
- `DATA_W`, 16: payload width (GPP word).
- `ID_W`, 16: node ID width.
- `DEPTH`, 16: entries per FIFO; power of two, ≥2.
- Derived `PKT_W = ID_W + DATA_W`. Packet layout: `[PKT_W-1:DATA_W]` is the destination ID; `[DATA_W-1:0]` is the payload.
- `clk` in 1: the single system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `node_id` in ID_W: this node's ID.
- `gpp_trf_dp` in 1: push `gpp_tx_data` into the TX FIFO.
- `gpp_tx_data` in DATA_W: TX write data.
- `data_tx_flag` in 1: control-plane request to start a burst.
- `tx_dest_id` in ID_W: burst destination, latched together with `data_tx_flag`.
- `data_tx_valid` out 1: packet strobe.
- `data_tx_last` out 1: final packet of the burst.
- `data_tx_packet` out PKT_W: outgoing packet.
- `data_tx_complete_flag` out 1: one-cycle pulse when a burst ends.
- `tx_full` out 1: TX FIFO full.
- `tx_level` out $clog2(DEPTH)+1: TX occupancy.
- `data_rx_valid` in 1: incoming packet strobe.
- `data_rx_last` in 1: incoming final packet.
- `data_rx_packet` in PKT_W: incoming packet.
- `gpp_rtr_dp` in 1: pop the RX FIFO.
- `RAM_rx_data_out` out DATA_W: popped RX word.
- `rx_empty` out 1: RX FIFO empty.
- `rx_level` out $clog2(DEPTH)+1: RX occupancy.
- `data_rx_complete_flag` out 1: one-cycle pulse on an accepted last packet.
- `rx_overflow` out 1: sticky; an accepted packet was lost because the RX FIFO was full.
- `rx_drop_cnt` out 8: dropped-packet counter (see Configuration).

## Operation
- **Reset.** Every output register returns to 0 and both FIFOs are emptied. `rx_empty` is 1 during reset. `tx_full` is 0. The TX state machine returns to TX_IDLE, including when reset arrives mid-burst.
- **TX FIFO push.** `gpp_trf_dp` pushes `gpp_tx_data` when the FIFO is not full. A push while full is ignored and the word is lost. A push and a pop in the same cycle leave `tx_level` unchanged.
- **TX_IDLE.**
  - On `data_tx_flag`, the block latches `tx_dest_id` and latches the burst length `len = tx_level` from that cycle.
  - If `len > 0`, it moves to TX_SEND.
  - If `len = 0`, it moves to TX_DONE and sends no packets.
- **TX_SEND.**
  - Each cycle it pops one word and drives `data_tx_valid = 1` with `data_tx_packet = {dest, word}`.
  - `data_tx_last = 1` on the packet with index `len-1`; it then moves to TX_DONE.
  - Words pushed during the burst are not sent in it. They stay queued for the next burst.
- **TX_DONE.** Drives `data_tx_complete_flag = 1` for one cycle, then returns to TX_IDLE.
- **Flag outside TX_IDLE.** `data_tx_flag` is ignored in TX_SEND and TX_DONE.
- **RX accept and drop.**
  - When `data_rx_valid = 1` and the packet's ID field equals `node_id`, the packet is accepted and its payload is pushed.
  - On an ID mismatch the packet is dropped.
  - An accepted packet that arrives while the RX FIFO is full is dropped and sets `rx_overflow`, which stays set until reset.
- **RX complete flag.** An accepted packet with `data_rx_last = 1` pulses `data_rx_complete_flag`, even if its payload overflowed.
- **RX pop.** `gpp_rtr_dp` pops when `rx_empty = 0` and updates `RAM_rx_data_out`. A pop while empty is ignored and `RAM_rx_data_out` holds its value. A push and a pop in the same cycle leave `rx_level` unchanged.
- **FIFO pointers.** Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. Occupancy is tracked with a separate counter.

## Timing
- All outputs are registered.
- **TX burst.** With `data_tx_flag` sampled at edge 0:
  - Packets appear on edges 1..len.
  - `data_tx_complete_flag` is high after edge len+1 for one cycle.
  - The earliest next flag is accepted at edge len+2.
- **Empty burst.** A flag with `len = 0` pulses the complete flag after edge 1.
- **RX.** An accepted packet at edge 0 updates `rx_level` and `rx_empty` after edge 0. The complete pulse follows edge 0.
- **Pop.** A pop at edge k puts the word on `RAM_rx_data_out` after edge k.
- **Read-after-write.** A push and a pop in the same cycle on an empty RX FIFO return nothing that cycle. The pushed word is poppable from the next cycle.

## Configuration
- **Macro `DATA_PLANE_DROP_CNT_EN`.**
  - Defined: `rx_drop_cnt` counts every RX packet that is dropped, whether by ID mismatch or overflow. It saturates at 255 and is cleared only by reset.
  - Undefined: `rx_drop_cnt` is tied to 0 and no counter logic is built.

## Structure
- **Package `data_plane_pkg`:**
  - `tx_state_t` enum (TX_IDLE, TX_SEND, TX_DONE).
  - Default `DATA_W`, `ID_W` and `DEPTH` constants.
  - Drop-counter width (8).
- **Sub-module `dp_fifo`:** a parametrised synchronous FIFO with push, pop, level, full, empty and a registered read. It is instantiated once for TX and once for RX.

## Test plan
- **Basic burst.** Push 0x1111, 0x2222, 0x3333, then raise the flag with `tx_dest_id = 5` → packets 0x00051111, 0x00052222, 0x00053333 on three consecutive cycles, last on the third, complete pulse on the next cycle.
- **Empty flag and mid-burst pushes.**
  - Flag with the TX FIFO empty → no valid, complete pulse one cycle later.
  - Push 0xAAAA during a 2-word burst → it is not sent; `tx_level = 1` after the burst.
- **RX filtering and overflow.**
  - `node_id = 3`: packets with IDs 3, 7, 3 (last) → `rx_level = 2`, one complete pulse, `rx_drop_cnt = 1` when the macro is defined.
  - Fill the RX FIFO to DEPTH, then send one more matching packet → `rx_overflow = 1`, `rx_level = DEPTH`.
- **Pointer wrap.** Push and pop 3×DEPTH words in interleaved order through both FIFOs → data order is preserved and levels match a reference model.
- **Reset mid-burst.** Assert `rst = 0` in the middle of a 4-word burst → `data_tx_valid` goes low immediately, levels read 0, no complete pulse, and the next flag behaves as a fresh burst.

Source files
------------

// File: rtl/data_plane_pkg.sv
// Shared types and defaults for the data plane: TX burst state encoding,
// default widths/depth and the drop-counter width.
package data_plane_pkg;
   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_DONE = 2'd2
   } tx_state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ID_W   = 16;
   localparam int DEF_DEPTH  = 16;
   localparam int DROP_CNT_W = 8;
endpackage

// File: rtl/dp_fifo.sv
// Synchronous FIFO with registered read data and a separate occupancy counter.
// Push is ignored while full, pop is ignored while empty.
module dp_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic          push_ok, pop_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= wdata;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         rdata <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok) begin
            rptr  <= rptr + 1'b1;
            rdata <= mem[rptr];
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/data_plane_gen.sv
// Data plane: TX FIFO drained as an addressed burst on data_tx_flag, RX packets
// filtered by node ID into an RX FIFO. DATA_PLANE_DROP_CNT_EN builds the drop counter.
module data_plane_gen
   import data_plane_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ID_W   = DEF_ID_W,
   parameter int DEPTH  = DEF_DEPTH,
   localparam int PKT_W = ID_W + DATA_W,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_W-1:0]       node_id,
   input  logic                  gpp_trf_dp,
   input  logic [DATA_W-1:0]     gpp_tx_data,
   input  logic                  data_tx_flag,
   input  logic [ID_W-1:0]       tx_dest_id,
   output logic                  data_tx_valid,
   output logic                  data_tx_last,
   output logic [PKT_W-1:0]      data_tx_packet,
   output logic                  data_tx_complete_flag,
   output logic                  tx_full,
   output logic [LW-1:0]         tx_level,
   input  logic                  data_rx_valid,
   input  logic                  data_rx_last,
   input  logic [PKT_W-1:0]      data_rx_packet,
   input  logic                  gpp_rtr_dp,
   output logic [DATA_W-1:0]     RAM_rx_data_out,
   output logic                  rx_empty,
   output logic [LW-1:0]         rx_level,
   output logic                  data_rx_complete_flag,
   output logic                  rx_overflow,
   output logic [DROP_CNT_W-1:0] rx_drop_cnt
);
   tx_state_t         state;
   logic [ID_W-1:0]   dest;
   logic [LW-1:0]     len, cnt;
   logic [DATA_W-1:0] tx_word;
   logic              tx_empty, tx_pop, rx_full, id_hit, rx_accept;

   assign tx_pop         = (state == TX_SEND) && !tx_empty;
   assign data_tx_packet = {dest, tx_word};

   dp_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(gpp_trf_dp), .pop(tx_pop), .wdata(gpp_tx_data),
      .rdata(tx_word), .level(tx_level), .full(tx_full), .empty(tx_empty)
   );

   // Burst length is frozen at the flag, so words pushed mid-burst wait for the next one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                 <= TX_IDLE;
         dest                  <= '0;
         len                   <= '0;
         cnt                   <= '0;
         data_tx_valid         <= 1'b0;
         data_tx_last          <= 1'b0;
         data_tx_complete_flag <= 1'b0;
      end else begin
         data_tx_complete_flag <= 1'b0;
         case (state)
            TX_IDLE: if (data_tx_flag) begin
               dest  <= tx_dest_id;
               len   <= tx_level;
               cnt   <= '0;
               state <= (tx_level != '0) ? TX_SEND : TX_DONE;
            end
            TX_SEND: begin
               data_tx_valid <= 1'b1;
               cnt           <= cnt + 1'b1;
               if (cnt == len - 1'b1) begin
                  data_tx_last <= 1'b1;
                  state        <= TX_DONE;
               end
            end
            TX_DONE: begin
               data_tx_valid         <= 1'b0;
               data_tx_last          <= 1'b0;
               data_tx_complete_flag <= 1'b1;
               state                 <= TX_IDLE;
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

   assign id_hit    = (data_rx_packet[PKT_W-1:DATA_W] == node_id);
   assign rx_accept = data_rx_valid && id_hit;

   dp_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_accept), .pop(gpp_rtr_dp),
      .wdata(data_rx_packet[DATA_W-1:0]), .rdata(RAM_rx_data_out),
      .level(rx_level), .full(rx_full), .empty(rx_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_rx_complete_flag <= 1'b0;
         rx_overflow           <= 1'b0;
      end else begin
         data_rx_complete_flag <= rx_accept && data_rx_last;
         if (rx_accept && rx_full) rx_overflow <= 1'b1;
      end
   end

`ifdef DATA_PLANE_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drop_q <= '0;
      else if (data_rx_valid && (!id_hit || rx_full) && (drop_q != '1))
         drop_q <= drop_q + 1'b1;
   end
   assign rx_drop_cnt = drop_q;
`else
   assign rx_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_data_plane_gen.sv
// Bench for data_plane_gen: directed scenarios plus random traffic against a
// queue-based model of bursts, RX filtering and FIFO occupancy.
module tb_data_plane_gen;
   localparam int DATA_W = 16, ID_W = 16, DEPTH = 16;
   localparam int PKT_W = ID_W + DATA_W, LW = $clog2(DEPTH) + 1;

   logic              clk = 1'b0, rst = 1'b0;
   logic [ID_W-1:0]   node_id = 16'd3;
   logic              gpp_trf_dp = 0, data_tx_flag = 0, data_rx_valid = 0, data_rx_last = 0, gpp_rtr_dp = 0;
   logic [DATA_W-1:0] gpp_tx_data = '0;
   logic [ID_W-1:0]   tx_dest_id = '0;
   logic [PKT_W-1:0]  data_rx_packet = '0;
   logic              data_tx_valid, data_tx_last, data_tx_complete_flag, tx_full;
   logic [PKT_W-1:0]  data_tx_packet;
   logic [LW-1:0]     tx_level, rx_level;
   logic [DATA_W-1:0] RAM_rx_data_out;
   logic              rx_empty, data_rx_complete_flag, rx_overflow;
   logic [7:0]        rx_drop_cnt;

   data_plane_gen #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .node_id(node_id), .gpp_trf_dp(gpp_trf_dp), .gpp_tx_data(gpp_tx_data),
      .data_tx_flag(data_tx_flag), .tx_dest_id(tx_dest_id), .data_tx_valid(data_tx_valid),
      .data_tx_last(data_tx_last), .data_tx_packet(data_tx_packet),
      .data_tx_complete_flag(data_tx_complete_flag), .tx_full(tx_full), .tx_level(tx_level),
      .data_rx_valid(data_rx_valid), .data_rx_last(data_rx_last), .data_rx_packet(data_rx_packet),
      .gpp_rtr_dp(gpp_rtr_dp), .RAM_rx_data_out(RAM_rx_data_out), .rx_empty(rx_empty),
      .rx_level(rx_level), .data_rx_complete_flag(data_rx_complete_flag),
      .rx_overflow(rx_overflow), .rx_drop_cnt(rx_drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: queues hold FIFO contents; a burst is a scheduled window of cycles.
   logic [DATA_W-1:0] txq[$], rxq[$];
   longint            cyc = 0, b_start = 0, next_ok = 0;
   int                b_len = 0, e_drop = 0;
   bit                b_act = 0;
   logic [ID_W-1:0]   b_dest = '0;
   logic              e_valid = 0, e_last = 0, e_tcmp = 0, e_rcmp = 0, e_ovf = 0;
   logic [PKT_W-1:0]  e_pkt = '0;
   logic [DATA_W-1:0] e_rdata = '0;

   task automatic model_reset();
      txq.delete(); rxq.delete();
      b_act = 0; next_ok = 0; e_drop = 0;
      e_valid = 0; e_last = 0; e_tcmp = 0; e_rcmp = 0; e_ovf = 0; e_rdata = '0;
   endtask

   task automatic model_edge();
      int tsz = txq.size();
      int rsz = rxq.size();
      bit m;
      logic [DATA_W-1:0] w;
      cyc++;
      if (data_tx_flag && cyc >= next_ok) begin
         b_act = 1; b_start = cyc; b_len = tsz; b_dest = tx_dest_id; next_ok = cyc + tsz + 2;
      end
      e_valid = 0; e_last = 0; e_tcmp = 0;
      if (b_act && cyc > b_start && cyc <= b_start + b_len) begin
         w = txq.pop_front();
         e_valid = 1; e_last = (cyc == b_start + b_len); e_pkt = {b_dest, w};
      end
      if (b_act && cyc == b_start + b_len + 1) e_tcmp = 1;
      if (gpp_trf_dp && tsz < DEPTH) txq.push_back(gpp_tx_data);
      m = data_rx_valid && (data_rx_packet[PKT_W-1:DATA_W] == node_id);
      if (gpp_rtr_dp && rsz > 0) e_rdata = rxq.pop_front();
      if (m && rsz < DEPTH) rxq.push_back(data_rx_packet[DATA_W-1:0]);
      if (m && rsz == DEPTH) e_ovf = 1;
      e_rcmp = m && data_rx_last;
      if (data_rx_valid && (!m || rsz == DEPTH) && e_drop < 255) e_drop++;
   endtask

   task automatic check_all();
      int exp_drop;
`ifdef DATA_PLANE_DROP_CNT_EN
      exp_drop = e_drop;
`else
      exp_drop = 0;
`endif
      chk("tx_valid", data_tx_valid, e_valid);
      chk("tx_last", data_tx_last, e_last);
      if (e_valid) chk("tx_packet", data_tx_packet, e_pkt);
      chk("tx_complete", data_tx_complete_flag, e_tcmp);
      chk("tx_level", tx_level, txq.size());
      chk("tx_full", tx_full, txq.size() == DEPTH);
      chk("rx_level", rx_level, rxq.size());
      chk("rx_empty", rx_empty, rxq.size() == 0);
      chk("rx_data", RAM_rx_data_out, e_rdata);
      chk("rx_complete", data_rx_complete_flag, e_rcmp);
      chk("rx_overflow", rx_overflow, e_ovf);
      chk("rx_drop_cnt", rx_drop_cnt, exp_drop);
   endtask

   task automatic idle();
      gpp_trf_dp = 0; data_tx_flag = 0; data_rx_valid = 0; data_rx_last = 0; gpp_rtr_dp = 0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      idle();
   endtask

   task automatic push_tx(input logic [DATA_W-1:0] d);
      gpp_trf_dp = 1; gpp_tx_data = d; step();
   endtask

   task automatic flag(input logic [ID_W-1:0] d);
      data_tx_flag = 1; tx_dest_id = d; step();
   endtask

   task automatic send_rx(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d, input logic last);
      data_rx_valid = 1; data_rx_last = last; data_rx_packet = {id, d}; step();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_all();
      @(negedge clk) rst = 1;

      // Basic burst
      push_tx(16'h1111); push_tx(16'h2222); push_tx(16'h3333);
      flag(16'd5);
      repeat (5) step();

      // Empty flag, then burst with a mid-burst push
      flag(16'd9);
      repeat (3) step();
      push_tx(16'h0101); push_tx(16'h0202);
      flag(16'd6);
      push_tx(16'hAAAA);
      repeat (4) step();
      flag(16'd6);
      repeat (3) step();

      // RX filtering
      send_rx(16'd3, 16'hBEEF, 0); send_rx(16'd7, 16'hDEAD, 0); send_rx(16'd3, 16'hCAFE, 1);
      step();
      repeat (3) begin gpp_rtr_dp = 1; step(); end

      // RX overflow
      for (int i = 0; i <= DEPTH; i++) send_rx(16'd3, 16'(i * 16'h0111), (i == DEPTH));
      step();
      repeat (DEPTH + 1) begin gpp_rtr_dp = 1; step(); end

      // Random traffic: wraps both FIFOs many times
      for (int i = 0; i < 700; i++) begin
         gpp_trf_dp     = 1'($urandom_range(0, 1));
         gpp_tx_data    = 16'($urandom);
         data_tx_flag   = ($urandom_range(0, 7) == 0);
         tx_dest_id     = 16'($urandom);
         data_rx_valid  = 1'($urandom_range(0, 1));
         data_rx_last   = 1'($urandom_range(0, 1));
         data_rx_packet = {($urandom_range(0, 2) != 0) ? node_id : 16'($urandom), 16'($urandom)};
         gpp_rtr_dp     = 1'($urandom_range(0, 1));
         step();
      end
      repeat (DEPTH + 2) begin gpp_rtr_dp = 1; step(); end
      data_tx_flag = 1; step();
      repeat (DEPTH + 3) step();

      // Reset in the middle of a 4-word burst
      for (int i = 0; i < 4; i++) push_tx(16'(16'h4000 + i));
      flag(16'd12);
      repeat (2) step();
      rst = 0;
      #1;
      chk("rst_tx_valid", data_tx_valid, 1'b0);
      chk("rst_tx_level", tx_level, 0);
      chk("rst_rx_level", rx_level, 0);
      model_reset();
      check_all();
      @(negedge clk) rst = 1;
      repeat (3) step();
      push_tx(16'h5555); push_tx(16'h6666);
      flag(16'd8);
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
